// File: rtl/day11_count_tx.sv
`default_nettype none
// ============================================================================
// Module   : day11_count_tx
// Purpose  : Stream transmitter for the day-11 count interface. Buffers up to
//            eight 64-bit path counts, then on start pulses load to the
//            consumer and streams N_COUNTS words in index order with
//            valid/last handshaking and ready backpressure.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   N_COUNTS      words streamed per frame (1..8)
// Ports
//   clock_i       sole clock, rising edge
//   clear_i       asynchronous active-high reset
//   wr_valid_i    buffer write strobe (honoured only in IDLE/DONE)
//   wr_idx_i      buffer slot to write (slots >= N_COUNTS ignored)
//   wr_data_i     count value to write
//   start_i       begin a frame (honoured only in IDLE/DONE)
//   ready_i       consumer ready; transfer on count_valid_o & ready_i
//   load_o        one-cycle consumer clear before each frame
//   count_o       buf[idx], shown in every state
//   count_valid_o high in SEND
//   count_last_o  high in SEND on slot N_COUNTS-1
//   busy_o        high in LOAD and SEND
//   done_o        high in DONE
//   idx_o         current send index
//   checksum_o    wrapping sum of words transferred this frame
//                 (present only when DAY11_COUNT_TX_CHECKSUM_EN is defined)
// ============================================================================
module day11_count_tx #(
  parameter int N_COUNTS = 6
) (
  input  logic        clock_i,
  input  logic        clear_i,
  input  logic        wr_valid_i,
  input  logic [2:0]  wr_idx_i,
  input  logic [63:0] wr_data_i,
  input  logic        start_i,
  input  logic        ready_i,
  output logic        load_o,
  output logic [63:0] count_o,
  output logic        count_valid_o,
  output logic        count_last_o,
  output logic        busy_o,
  output logic        done_o,
  output logic [2:0]  idx_o
`ifdef DAY11_COUNT_TX_CHECKSUM_EN
  ,
  output logic [63:0] checksum_o
`endif
);

  localparam logic [1:0] c_ST_IDLE = 2'd0;
  localparam logic [1:0] c_ST_LOAD = 2'd1;
  localparam logic [1:0] c_ST_SEND = 2'd2;
  localparam logic [1:0] c_ST_DONE = 2'd3;

  localparam logic [3:0] c_NUM  = 4'(N_COUNTS);
  localparam logic [2:0] c_LAST = 3'(N_COUNTS - 1);

  logic [1:0]  state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [63:0] buf_q [0:7];

  logic w_idle_or_done;
  logic w_wr_en;
  logic w_xfer;
  logic w_at_last;

  // The buffer is writable only between frames so a frame always sees a
  // stable snapshot; out-of-range slots are silently dropped.
  assign w_idle_or_done = (state_q == c_ST_IDLE) || (state_q == c_ST_DONE);
  assign w_wr_en        = wr_valid_i && w_idle_or_done && ({1'b0, wr_idx_i} < c_NUM);
  assign w_xfer         = (state_q == c_ST_SEND) && ready_i;
  assign w_at_last      = (idx_q == c_LAST);

  // --------------------------------------------------------------------------
  // Count buffer
  // --------------------------------------------------------------------------
  for (genvar g = 0; g < 8; g++) begin : g_buf
    always_ff @(posedge clock_i or posedge clear_i) begin
      if (clear_i) begin
        buf_q[g] <= 64'd0;
      end else if (w_wr_en && (wr_idx_i == 3'(g))) begin
        buf_q[g] <= wr_data_i;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Frame state machine
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      c_ST_IDLE, c_ST_DONE: begin
        if (start_i) begin
          state_d = c_ST_LOAD;
          idx_d   = 3'd0;
        end
      end
      c_ST_LOAD: begin
        state_d = c_ST_SEND;
      end
      c_ST_SEND: begin
        if (w_xfer) begin
          // idx stops at the last slot so DONE still reports it.
          if (w_at_last) begin
            state_d = c_ST_DONE;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      default: begin
        state_d = c_ST_IDLE;
        idx_d   = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clock_i or posedge clear_i) begin
    if (clear_i) begin
      state_q <= c_ST_IDLE;
      idx_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // All outputs decode registers only; ready_i never reaches an output.
  assign load_o        = (state_q == c_ST_LOAD);
  assign count_o       = buf_q[idx_q];
  assign count_valid_o = (state_q == c_ST_SEND);
  assign count_last_o  = (state_q == c_ST_SEND) && w_at_last;
  assign busy_o        = (state_q == c_ST_LOAD) || (state_q == c_ST_SEND);
  assign done_o        = (state_q == c_ST_DONE);
  assign idx_o         = idx_q;

`ifdef DAY11_COUNT_TX_CHECKSUM_EN
  // --------------------------------------------------------------------------
  // Frame checksum: wraps modulo 2^64, cleared in LOAD, frozen in DONE.
  // --------------------------------------------------------------------------
  logic [63:0] checksum_q, checksum_d;

  always_comb begin
    checksum_d = checksum_q;
    if (state_q == c_ST_LOAD) begin
      checksum_d = 64'd0;
    end else if (w_xfer) begin
      checksum_d = checksum_q + buf_q[idx_q];
    end
  end

  always_ff @(posedge clock_i or posedge clear_i) begin
    if (clear_i) begin
      checksum_q <= 64'd0;
    end else begin
      checksum_q <= checksum_d;
    end
  end

  assign checksum_o = checksum_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_day11_count_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_day11_count_tx
// Purpose  : Self-checking bench for day11_count_tx (N_COUNTS = 6).
// Revision : 1.0 - initial release
// ============================================================================
module tb_day11_count_tx;

  logic        clock;
  logic        clear;
  logic        wr_valid;
  logic [2:0]  wr_idx;
  logic [63:0] wr_data;
  logic        start;
  logic        ready;
  logic        load;
  logic [63:0] count;
  logic        count_valid;
  logic        count_last;
  logic        busy;
  logic        done_;
  logic [2:0]  idx;
`ifdef DAY11_COUNT_TX_CHECKSUM_EN
  logic [63:0] checksum;
`endif

  day11_count_tx #(.N_COUNTS(6)) dut (
    .clock_i       (clock),
    .clear_i       (clear),
    .wr_valid_i    (wr_valid),
    .wr_idx_i      (wr_idx),
    .wr_data_i     (wr_data),
    .start_i       (start),
    .ready_i       (ready),
    .load_o        (load),
    .count_o       (count),
    .count_valid_o (count_valid),
    .count_last_o  (count_last),
    .busy_o        (busy),
    .done_o        (done_),
    .idx_o         (idx)
`ifdef DAY11_COUNT_TX_CHECKSUM_EN
    ,
    .checksum_o    (checksum)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        ready;
    logic        load;
    logic        valid;
    logic        last;
    logic        busy;
    logic        done;
    logic [2:0]  idx;
    logic [63:0] count;
  } vec_t;

  vec_t tbl_basic[$];
  vec_t tbl_bp[$];
  vec_t tbl_zero[$];

  int n_cmp = 0;
  int n_bad = 0;

  function automatic vec_t mk(logic r, logic ld, logic v, logic l, logic b,
                              logic d, logic [2:0] i, logic [63:0] c);
    vec_t t;
    t.ready = r; t.load = ld; t.valid = v; t.last = l;
    t.busy = b; t.done = d; t.idx = i; t.count = c;
    return t;
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(string name, logic [71:0] act, logic [71:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (load,valid,last,busy,done,idx,count)",
               name, act, exp);
    end
  endtask

  function automatic logic [71:0] outs();
    return {load, count_valid, count_last, busy, done_, idx, count};
  endfunction

  task automatic wr(logic [2:0] i, logic [63:0] d);
    wr_valid = 1'b1; wr_idx = i; wr_data = d;
    step();
    wr_valid = 1'b0;
  endtask

  // Apply one frame table cycle by cycle. With inject set, a write to slot 2
  // and a stray start are driven mid-frame; both must be ignored.
  task automatic run_table(string name, input vec_t q[$], input bit inject);
    for (int i = 0; i < q.size(); i++) begin
      ready = q[i].ready;
      if (inject && i == 2) begin
        wr_valid = 1'b1; wr_idx = 3'd2; wr_data = 64'd42; start = 1'b1;
      end else begin
        wr_valid = 1'b0; start = 1'b0;
      end
      check($sformatf("%s[%0d]", name, i), outs(),
            {q[i].load, q[i].valid, q[i].last, q[i].busy, q[i].done, q[i].idx, q[i].count});
      step();
    end
    wr_valid = 1'b0; start = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(string name, int budget);
    for (int c = 0; c < budget && !done_; c++) step();
    n_cmp++;
    if (done_ !== 1'b1) begin
      n_bad++;
      $display("FAIL %s: done_ got %b expected 1 within %0d cycles", name, done_, budget);
    end
  endtask

  initial begin
    logic [63:0] d [0:5];
    logic [2:0]  bp_idx [0:11];
    logic        bp_rdy [0:11];
    d = '{64'd2, 64'd3, 64'd5, 64'd7, 64'd11, 64'd13};
    bp_idx = '{3'd0, 3'd1, 3'd1, 3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd4, 3'd5, 3'd5, 3'd5};
    bp_rdy = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

    // Frame tables: LOAD cycle, six SEND cycles, then DONE.
    tbl_basic.push_back(mk(1, 1, 0, 0, 1, 0, 3'd0, d[0]));
    tbl_zero.push_back(mk(1, 1, 0, 0, 1, 0, 3'd0, 64'd0));
    for (int k = 0; k < 6; k++) begin
      tbl_basic.push_back(mk(1, 0, 1, k == 5, 1, 0, 3'(k), d[k]));
      tbl_zero.push_back(mk(1, 0, 1, k == 5, 1, 0, 3'(k), 64'd0));
    end
    tbl_basic.push_back(mk(1, 0, 0, 0, 0, 1, 3'd5, d[5]));
    tbl_zero.push_back(mk(1, 0, 0, 0, 0, 1, 3'd5, 64'd0));

    tbl_bp.push_back(mk(1, 1, 0, 0, 1, 0, 3'd0, d[0]));
    for (int p = 0; p < 12; p++)
      tbl_bp.push_back(mk(bp_rdy[p], 0, 1, bp_idx[p] == 3'd5, 1, 0, bp_idx[p], d[bp_idx[p]]));
    tbl_bp.push_back(mk(1, 0, 0, 0, 0, 1, 3'd5, d[5]));

    // Reset then idle.
    clear = 1'b1; wr_valid = 1'b0; wr_idx = 3'd0; wr_data = 64'd0;
    start = 1'b0; ready = 1'b1;
    #1;
    check("reset_state", outs(), 72'd0);
    step(); step();
    clear = 1'b0;
    for (int c = 0; c < 10; c++) begin
      step();
      check($sformatf("idle[%0d]", c), outs(), 72'd0);
    end

    // Basic frame.
    for (int k = 0; k < 6; k++) wr(3'(k), d[k]);
    pulse_start();
    run_table("basic", tbl_basic, 1'b0);

    // Backpressure frame, restarted from DONE.
    pulse_start();
    run_table("bp", tbl_bp, 1'b0);

    // Out-of-range write, then a frame with a dropped mid-frame write and
    // stray start, then a resend from DONE.
    wr(3'd6, 64'd99);
    pulse_start();
    run_table("ignwr", tbl_basic, 1'b1);
    pulse_start();
    run_table("resend", tbl_basic, 1'b0);

    // Start and write in the same DONE cycle: frame uses the new value.
    wr_valid = 1'b1; wr_idx = 3'd0; wr_data = 64'd77; start = 1'b1;
    step();
    wr_valid = 1'b0; start = 1'b0;
    check("sw_load", outs(), {5'b10010, 3'd0, 64'd77});
    step();
    check("sw_word0", outs(), {5'b01010, 3'd0, 64'd77});
    wait_done("sw_done", 20);
    wr(3'd0, d[0]);

    // Asynchronous clear after word 2 is accepted.
    pulse_start();
    step(); step(); step(); step();
    check("mid_idx3", outs(), {5'b01010, 3'd3, d[3]});
    #1 clear = 1'b1;
    #1 check("mid_clear", outs(), 72'd0);
    #1 clear = 1'b0;
    pulse_start();
    run_table("zeros", tbl_zero, 1'b0);

`ifdef DAY11_COUNT_TX_CHECKSUM_EN
    wr(3'd0, 64'h8000_0000_0000_0000);
    wr(3'd1, 64'h8000_0000_0000_0000);
    wr(3'd2, 64'd1);
    wr(3'd3, 64'd2);
    wr(3'd4, 64'd3);
    wr(3'd5, 64'd4);
    pulse_start();
    wait_done("csum_done", 20);
    n_cmp++;
    if (checksum !== 64'd10) begin
      n_bad++;
      $display("FAIL checksum: got %0d expected 10", checksum);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/day11_count_tx.md
# day11_count_tx

Stream transmitter for the day-11 count interface. Holds up to eight 64-bit path counts written by the upstream path-counting engine, then, on `start`, pulses the consumer's `load`, streams the counts in index order with `count_valid`/`count_last`, and honours the consumer's `ready` backpressure. It sits between the path-count engine and the day-11 result combiner, driving that combiner's `count`, `count_valid`, `count_last` and `load` inputs.

## Interface

- `N_COUNTS`, default 6: number of words streamed per frame. Legal range 1..8.
- `clock`  in  1  sole clock, rising edge.
- `clear`  in  1  asynchronous, active-high reset.
- `wr_valid`  in  1  write strobe into the count buffer.
- `wr_idx`  in  3  buffer slot to write.
- `wr_data`  in  64  count value to write.
- `start`  in  1  begin one frame; single-cycle pulse expected.
- `ready`  in  1  consumer ready; a word transfers when `count_valid & ready`.
- `load`  out  1  one-cycle pulse that clears the consumer before a frame.
- `count`  out  64  current word, equal to `buf[idx]`.
- `count_valid`  out  1  `count` is valid.
- `count_last`  out  1  current word is slot `N_COUNTS-1`.
- `busy`  out  1  high in LOAD and SEND.
- `done_`  out  1  high in DONE.
- `idx`  out  3  current send index.

## Operation

- Buffer: eight 64-bit registers `buf[0..7]`, reset to 0.
  - Write on `wr_valid` only in IDLE or DONE.
  - Writes with `wr_idx >= N_COUNTS` are ignored.
  - Writes in LOAD or SEND are dropped; the buffer is stable for the whole frame.
- State machine with four states: IDLE, LOAD, SEND, DONE.
  - IDLE: on `start`, go to LOAD and set `idx=0`.
  - LOAD: lasts exactly one cycle with `load=1`, then goes to SEND.
  - SEND: `count_valid=1` and `count=buf[idx]`.
    - On transfer with `idx < N_COUNTS-1`: `idx+=1`.
    - On transfer with `idx == N_COUNTS-1`: go to DONE and hold `idx`.
    - With `ready=0`, `count`, `idx` and `count_last` hold.
  - DONE: `done_=1`. On `start`, go to LOAD and set `idx=0`, so the same buffer can be resent.
- `start` in LOAD or SEND is ignored.
- `start` and `wr_valid` in the same cycle while in IDLE or DONE: the write commits and the state moves to LOAD. The frame uses the newly written value.
- `count_last = (state==SEND) & (idx==N_COUNTS-1)`.
- Outside SEND, `count_valid=0`, `count_last=0`, and `count` still shows `buf[idx]`.
- `idx` never wraps; the maximum value it reaches is `N_COUNTS-1`.
- All arithmetic is unsigned. Values pass through unmodified.

## Timing

- Reset values: state IDLE, `idx=0`, all `buf=0`, `load=0`, `count_valid=0`, `count_last=0`, `busy=0`, `done_=0`, `count=0`.
- `clear` mid-frame returns the block to reset values immediately (asynchronously). The frame is abandoned and the buffer is cleared.
- Frame latency with `ready` held high:
  - `start` is sampled at edge T.
  - `load=1` during cycle T+1.
  - Word 0 is valid during cycle T+2.
  - Word k is valid during cycle T+2+k.
  - `done_=1` from cycle T+2+N_COUNTS.
- Each stall cycle (`ready=0` in SEND) adds one cycle of latency.
- Throughput is one word per cycle. No bubbles between words.
- All outputs are registered or decoded directly from registers. There is no combinational path from `ready` to any output.

## Configuration

- `DAY11_COUNT_TX_CHECKSUM_EN` defined:
  - Adds output `checksum` (64 bits), a wrapping sum of all words transferred in the current frame.
  - It is cleared to 0 in the LOAD cycle and on reset.
  - It updates on each transfer and holds in DONE.
- Undefined: the `checksum` port and its adder do not exist. All other behaviour is identical.

## Test plan

- Reset then idle: assert `clear` asynchronously mid-cycle -> all outputs 0 at once; no `count_valid` for 10 cycles without `start`.
- Basic frame, `ready=1`: write buf = 2,3,5,7,11,13, pulse `start` -> `load` for 1 cycle, then `count` sequence 2,3,5,7,11,13 on consecutive cycles, `count_last` only on 13, then `done_=1`, `idx=5`.
- Backpressure: same data, `ready` toggling 1,0,0,1,… -> each word held stable while `ready=0`, no word dropped or duplicated, order unchanged.
- Illegal and ignored writes: write `wr_idx=6` with data 99 (N_COUNTS=6), then write slot 2 with data 42 during SEND -> frame unchanged; following frame started from DONE resends the original values with no 99 or 42.
- Reset mid-frame: `clear` after word 2 is accepted -> state IDLE, buf all 0; a new `start` streams six zeros.
- With `DAY11_COUNT_TX_CHECKSUM_EN` defined, send values 2^63 twice plus 1,2,3,4 -> `checksum=10` at DONE (wrap verified).
